// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } fetch_state_t;

    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with synchronous flush; push and pop may coincide.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffered.sv
// Fetch unit: PC sequencer with icache miss handling, redirect flush and an
// instruction queue. Perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_buffered
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          INST_W   = 16,
    parameter int unsigned          QDEPTH   = 4,
    parameter logic [INST_W-1:0]    NOP_INST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] init_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_code,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_hit,
    input  logic [INST_W-1:0] ic_inst,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned EW = ADDR_W + INST_W;

    fetch_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  q_push, q_pop, q_full, q_empty;
    logic [$clog2(QDEPTH):0] q_count;
    logic [EW-1:0]         q_dout;

    // Redirect suppresses both the request (hence the push) and the pop.
    assign q_push     = ic_req && ic_hit;
    assign q_pop      = !q_empty && dec_ready && !redirect_valid;
    assign inst_valid = (q_count != '0);
    assign inst_code  = inst_valid ? q_dout[INST_W-1:0] : NOP_INST;
    assign inst_pc    = inst_valid ? q_dout[EW-1:INST_W] : '0;
    assign ic_addr    = pc_q;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   ({pc_q, ic_inst}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= init_pc;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ic_req  = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, MISS: begin
                ic_req = !q_full && !redirect_valid;
                if (ic_req) begin
                    if (ic_hit) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = RUN;
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = RUN;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] miss_q, flush_q;
    logic             miss_event;

    // Only the RUN->MISS transition counts; a miss that persists is one event.
    assign miss_event = (state_q == RUN) && ic_req && !ic_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            miss_q  <= '0;
            flush_q <= '0;
        end else begin
            if (miss_event)     miss_q  <= sat_inc(miss_q);
            if (redirect_valid) flush_q <= sat_inc(flush_q);
        end
    end

    assign miss_cnt  = miss_q;
    assign flush_cnt = flush_q;
`else
    assign miss_cnt  = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed self-checking bench for fetch_buffered (QDEPTH=4, 16-bit PC/inst).
module tb_fetch_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] init_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [15:0] inst_code;
    logic [15:0] inst_pc;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic        ic_hit;
    logic [15:0] ic_inst;
    logic [15:0] miss_cnt;
    logic [15:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam logic [15:0] EXP_ONE = 16'd1;
`else
    localparam logic [15:0] EXP_ONE = 16'd0;
`endif

    always #5 clk = ~clk;

    // Icache model: instruction word is a fixed scramble of its address.
    assign ic_inst = ic_addr ^ 16'hA5A5;

    fetch_buffered #(
        .ADDR_W   (16),
        .INST_W   (16),
        .QDEPTH   (4),
        .NOP_INST (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .init_pc        (init_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .inst_valid     (inst_valid),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_hit         (ic_hit),
        .ic_inst        (ic_inst),
        .miss_cnt       (miss_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input logic [15:0] pc);
        init_pc        = pc;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        init_pc        = 16'h0040;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        dec_ready      = 1'b1;
        ic_hit         = 1'b1;

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_ic_req", ic_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_code", inst_code, 16'h0000);
        chk("rst_inst_pc", inst_pc, 16'h0000);
        chk("rst_ic_addr", ic_addr, 16'h0040);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // Streaming fetch from boot address
        reset = 1'b1;
        tick();
        chk("boot_ic_req", ic_req, 1);
        chk("stream_addr0", ic_addr, 16'h0040);
        chk("stream_empty0", inst_valid, 0);
        tick();
        chk("stream_addr1", ic_addr, 16'h0041);
        chk("stream_valid1", inst_valid, 1);
        chk("stream_pc1", inst_pc, 16'h0040);
        chk("stream_code1", inst_code, 16'h0040 ^ 16'hA5A5);
        tick();
        chk("stream_addr2", ic_addr, 16'h0042);
        chk("stream_pc2", inst_pc, 16'h0041);

        // Fill queue with decode stalled
        dec_ready = 1'b0;
        do_reset(16'h0100);
        tick();
        tick();
        tick();
        chk("fill_req3", ic_req, 1);
        chk("fill_addr3", ic_addr, 16'h0103);
        tick();
        chk("full_req", ic_req, 0);
        chk("full_addr", ic_addr, 16'h0104);
        chk("full_head", inst_pc, 16'h0100);
        tick();
        tick();
        chk("full_hold_addr", ic_addr, 16'h0104);
        chk("full_hold_req", ic_req, 0);
        dec_ready = 1'b1;
        tick();
        chk("drain_head", inst_pc, 16'h0101);
        chk("drain_req", ic_req, 1);

        // Miss for 5 cycles at 0x0010
        do_reset(16'h0010);
        ic_hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("miss_addr", ic_addr, 16'h0010);
            chk("miss_empty", inst_valid, 0);
        end
        ic_hit = 1'b1;
        tick();
        chk("miss_done_valid", inst_valid, 1);
        chk("miss_done_pc", inst_pc, 16'h0010);
        chk("miss_done_addr", ic_addr, 16'h0011);
        chk("miss_cnt", miss_cnt, EXP_ONE);
        tick();
        chk("miss_one_push", inst_pc, 16'h0011);

        // Redirect with 3 entries queued
        dec_ready = 1'b0;
        do_reset(16'h0020);
        tick();
        tick();
        tick();
        chk("pre_redir_valid", inst_valid, 1);
        chk("pre_redir_addr", ic_addr, 16'h0023);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        dec_ready      = 1'b1;
        settle();
        chk("redir_req_off", ic_req, 0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("redir_flushed", inst_valid, 0);
        chk("redir_addr", ic_addr, 16'h0200);
        chk("redir_nop", inst_code, 16'h0000);
        chk("flush_cnt", flush_cnt, EXP_ONE);
        tick();
        chk("redir_first", inst_pc, 16'h0200);

        // Redirect during miss, hit arriving the same cycle
        do_reset(16'h0010);
        ic_hit = 1'b0;
        tick();
        tick();
        ic_hit         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("mredir_empty", inst_valid, 0);
        chk("mredir_addr", ic_addr, 16'h0300);
        tick();
        chk("mredir_pc", inst_pc, 16'h0300);

        // PC wraparound
        do_reset(16'hFFFF);
        tick();
        chk("wrap_addr", ic_addr, 16'h0000);
        chk("wrap_pc", inst_pc, 16'hFFFF);

        // Reset in the middle of a miss
        do_reset(16'h0010);
        ic_hit = 1'b0;
        tick();
        reset  = 1'b0;
        ic_hit = 1'b1;
        tick();
        chk("rmiss_valid", inst_valid, 0);
        chk("rmiss_req", ic_req, 0);
        reset = 1'b1;
        tick();
        chk("rmiss_post_valid", inst_valid, 0);
        chk("rmiss_post_addr", ic_addr, 16'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
